tdc_meas_sequencer: RTL and testbench
=====================================

# tdc_meas_sequencer

Measurement controller for the ring-oscillator TDC. It generates the TDC `start`/`stop` pair with a programmable start-to-stop interval and repeats the measurement 2^N times. Each TDC `time_count` is accumulated, and the averaged 32-bit result is presented byte-wise for the 8-bit `uo_out` pins. It sits in the tile top between `ui_in` and the TDC instance, replacing direct pin drive of start/stop.

## Interface
Parameters:
- `CNT_W`, 32, width of the TDC count and of `result`
- `DLY_W`, 8, width of `delay_cycles`
- `SETTLE`, 2, cycles `stop` is held before the count is sampled (≥1)
- `GAP`, 2, idle cycles with start/stop low between measurements (≥1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `go`  in  1  level-sampled request; starts a campaign when sampled high in IDLE
- `abort`  in  1  synchronous abort of a running campaign
- `delay_cycles`  in  DLY_W  start-to-stop interval in clk cycles, latched on go
- `avg_log2`  in  3  number of measurements = 2^avg_log2 (1..128), latched on go
- `tdc_start`  out  1  registered TDC start
- `tdc_stop`  out  1  registered TDC stop
- `tdc_count`  in  CNT_W  TDC transition count
- `busy`  out  1  campaign in progress
- `done`  out  1  one-cycle pulse, `result` updated
- `result`  out  CNT_W  registered averaged count
- `byte_sel`  in  2  byte select for `result_byte`
- `result_byte`  out  8  `result[8*byte_sel +: 8]`, combinational mux

## Operation
- States: IDLE, START, SETTLE, GAP, FINISH.
- IDLE: start=stop=0, busy=0. On go=1:
  - latch D = max(delay_cycles,1) and avg_log2;
  - clear the accumulator and the measurement counter;
  - go to START.
- START: start=1, stop=0 for D cycles, then SETTLE.
- SETTLE: start=1, stop=1 for SETTLE cycles.
  - At the edge leaving the last SETTLE cycle, add `tdc_count` to the accumulator.
  - Then go to GAP.
- GAP: start=stop=0 for GAP cycles. Then:
  - if the measurement counter = 2^avg_log2 − 1, go to FINISH;
  - else increment the counter and go to START.
- FINISH: one cycle. done=1, busy=0, `result` = accumulator >> avg_log2, truncated to CNT_W. Then IDLE.
- busy = 1 in START, SETTLE and GAP only.
- Arithmetic:
  - accumulator width is CNT_W+7 and cannot overflow at 128 × (2^CNT_W − 1);
  - the shift is logical, so this is a floor average.
- go outside IDLE is ignored. go held high re-triggers on the cycle after FINISH returns to IDLE.
- abort=1 in START, SETTLE or GAP:
  - go to IDLE next edge, outputs low;
  - no done pulse;
  - `result` keeps its previous value;
  - abort has priority over all transitions.
- abort in IDLE or FINISH has no effect; FINISH completes normally.
- `delay_cycles`/`avg_log2` changes during a campaign have no effect.

## Timing
- Reset (rst_n low at an edge):
  - state IDLE;
  - tdc_start=0, tdc_stop=0, busy=0, done=0;
  - result=0, accumulator=0, counter=0.
- Reset mid-campaign behaves like reset: no done, result cleared.
- All outputs except `result_byte` are registered.
- Cycle numbering: go sampled at edge 0 (start of cycle 1).
  - Cycles 1..D: start=1.
  - Cycles D+1..D+SETTLE: start=stop=1.
  - Count is sampled at the end of cycle D+SETTLE.
  - Next GAP cycles: both low.
- One measurement lasts D+SETTLE+GAP cycles.
- done fires in cycle 2^avg_log2·(D+SETTLE+GAP)+1.
- A new go is accepted at the earliest in the cycle after done.

## Structure
- Shared package `tdc_pkg` holds:
  - the state enum `tdc_seq_state_t`;
  - default CNT_W, DLY_W, SETTLE, GAP;
  - accumulator width CNT_W+7.
- One natural sub-module, `tdc_avg_accum`:
  - clear/add/shift accumulator;
  - inputs clear, add_en, sample, shift amount;
  - output the averaged CNT_W value.
- FSM, interval counter and byte mux live in `tdc_meas_sequencer`.
- Tile top maps:
  - go=ui_in[0], abort=ui_in[1];
  - byte_sel=ui_in[3:2], avg_log2=ui_in[6:4];
  - delay_cycles from a constant;
  - uo_out = result_byte.

## Test plan
- Reset then idle: rst_n low 2 cycles, go=0 → all outputs 0, result_byte=0x00 for all byte_sel.
- Single shot: delay_cycles=4, avg_log2=0, tdc_count=0x0000_1234 stable, go pulsed → start high cycles 1–6, stop high cycles 5–6, both low 7–8, done cycle 9, result=0x1234, result_byte=0x34/0x12/0x00/0x00 for byte_sel 0..3.
- Averaging: avg_log2=2, tdc_count=10,11,12,14 per sample → exactly 4 start pulses, result=11 (47>>2), done once.
- Zero delay: delay_cycles=0 → start alone high exactly 1 cycle before stop rises.
- Abort: abort in GAP of 2nd of 4 measurements → IDLE next cycle, start/stop low, no done, result unchanged from prior campaign.
- Boundaries:
  - go held high through a campaign → no retrigger until after FINISH;
  - tdc_count=0xFFFF_FFFF with avg_log2=7 → result=0xFFFF_FFFF, no overflow;
  - rst_n low mid-SETTLE → all outputs 0 next cycle.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement sequencer: state encoding and
// default widths/timing.
package tdc_pkg;
    localparam int CNT_W_DEF  = 32;
    localparam int DLY_W_DEF  = 8;
    localparam int SETTLE_DEF = 2;
    localparam int GAP_DEF    = 2;

    // Headroom bits so 128 full-scale samples never overflow the sum.
    localparam int ACC_EXTRA  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_GAP,
        S_FINISH
    } tdc_seq_state_t;
endpackage

// File: rtl/tdc_avg_accum.sv
// Sum of TDC samples with clear/add control; the average is a logical
// right shift of the sum, i.e. a floor average.
module tdc_avg_accum
    import tdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             add_en,
    input  logic [CNT_W-1:0] sample,
    input  logic [2:0]       shift,
    output logic [CNT_W-1:0] avg
);
    localparam int ACC_W = CNT_W + ACC_EXTRA;

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (!rst_n)      acc <= '0;
        else if (clear)  acc <= '0;
        else if (add_en) acc <= acc + ACC_W'(sample);
    end

    assign avg = CNT_W'(acc >> shift);
endmodule

// File: rtl/tdc_meas_sequencer.sv
// TDC start/stop sequencer: runs 2^avg_log2 measurements with a programmable
// start-to-stop interval and presents the averaged count byte-wise.
module tdc_meas_sequencer
    import tdc_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int GAP    = GAP_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [DLY_W-1:0] delay_cycles,
    input  logic [2:0]       avg_log2,
    output logic             tdc_start,
    output logic             tdc_stop,
    input  logic [CNT_W-1:0] tdc_count,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    input  logic [1:0]       byte_sel,
    output logic [7:0]       result_byte
);
    localparam logic [DLY_W-1:0] SET_LAST = DLY_W'(SETTLE - 1);
    localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(GAP - 1);

    tdc_seq_state_t   state, state_nx;
    logic [DLY_W-1:0] tmr, tmr_nx, d_lat;
    logic [2:0]       n_lat;
    logic [6:0]       meas_cnt, meas_last;
    logic             clear, add_en, meas_inc, running;
    logic [CNT_W-1:0] avg;

    assign running   = (state == S_START) || (state == S_SETTLE) || (state == S_GAP);
    assign meas_last = 7'h7f >> (3'd7 - n_lat);

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        clear    = 1'b0;
        add_en   = 1'b0;
        meas_inc = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_nx = '0;
                if (go) begin
                    state_nx = S_START;
                    clear    = 1'b1;
                end
            end
            S_START: begin
                if (tmr == d_lat - 1'b1) begin
                    state_nx = S_SETTLE;
                    tmr_nx   = '0;
                end else tmr_nx = tmr + 1'b1;
            end
            S_SETTLE: begin
                if (tmr == SET_LAST) begin
                    state_nx = S_GAP;
                    tmr_nx   = '0;
                    add_en   = 1'b1;
                end else tmr_nx = tmr + 1'b1;
            end
            S_GAP: begin
                if (tmr == GAP_LAST) begin
                    tmr_nx = '0;
                    if (meas_cnt == meas_last) state_nx = S_FINISH;
                    else begin
                        state_nx = S_START;
                        meas_inc = 1'b1;
                    end
                end else tmr_nx = tmr + 1'b1;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        // Abort overrides every transition, including the final sample add.
        if (abort && running) begin
            state_nx = S_IDLE;
            tmr_nx   = '0;
            add_en   = 1'b0;
            meas_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tmr      <= '0;
            d_lat    <= '0;
            n_lat    <= '0;
            meas_cnt <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
            if (clear) begin
                d_lat    <= (delay_cycles == '0) ? DLY_W'(1) : delay_cycles;
                n_lat    <= avg_log2;
                meas_cnt <= '0;
            end else if (meas_inc) meas_cnt <= meas_cnt + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdc_start <= 1'b0;
            tdc_stop  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            tdc_start <= (state_nx == S_START) || (state_nx == S_SETTLE);
            tdc_stop  <= (state_nx == S_SETTLE);
            busy      <= (state_nx == S_START) || (state_nx == S_SETTLE) || (state_nx == S_GAP);
            done      <= (state_nx == S_FINISH);
            if (state_nx == S_FINISH) result <= avg;
        end
    end

    tdc_avg_accum #(.CNT_W(CNT_W)) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .add_en (add_en),
        .sample (tdc_count),
        .shift  (n_lat),
        .avg    (avg)
    );

    assign result_byte = 8'(result >> {byte_sel, 3'b000});
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed and randomized campaigns checked against a cycle-numbered model of
// the start/stop waveform and a floor-average of the driven samples.
module tb_tdc_meas_sequencer;
    localparam int CNT_W  = 32;
    localparam int DLY_W  = 8;
    localparam int SETTLE = 2;
    localparam int GAP    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             go = 1'b0;
    logic             abort = 1'b0;
    logic [DLY_W-1:0] delay_cycles = '0;
    logic [2:0]       avg_log2 = '0;
    logic             tdc_start, tdc_stop, busy, done;
    logic [CNT_W-1:0] tdc_count = '0;
    logic [CNT_W-1:0] result;
    logic [1:0]       byte_sel = '0;
    logic [7:0]       result_byte;

    int          cmp = 0;
    int          mis = 0;
    logic [31:0] g_res = '0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_val = '0;
    logic [31:0] preset_q[$];

    always #5 clk = ~clk;

    tdc_meas_sequencer #(
        .CNT_W(CNT_W), .DLY_W(DLY_W), .SETTLE(SETTLE), .GAP(GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .abort        (abort),
        .delay_cycles (delay_cycles),
        .avg_log2     (avg_log2),
        .tdc_start    (tdc_start),
        .tdc_stop     (tdc_stop),
        .tdc_count    (tdc_count),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .byte_sel     (byte_sel),
        .result_byte  (result_byte)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] r);
        for (int k = 0; k < 4; k++) begin
            byte_sel = 2'(k);
            #1;
            check(tag, 64'(result_byte), 64'((r >> (8 * k)) & 32'hff));
        end
        byte_sel = '0;
    endtask

    function automatic logic [31:0] sample_val();
        if (preset_q.size() != 0) return preset_q.pop_front();
        if (use_fixed) return fixed_val;
        return $urandom;
    endfunction

    function automatic logic [31:0] junk_val();
        return use_fixed ? fixed_val : $urandom;
    endfunction

    // {start, stop, busy, done} in cycle c after go was sampled.
    function automatic logic [3:0] exp_vec(input int c, input int d, input int np, input int p);
        int ph;
        if (c <= np) begin
            ph = (c - 1) % p;
            return {ph < d + SETTLE, (ph >= d) && (ph < d + SETTLE), 1'b1, 1'b0};
        end
        if (c == np + 1) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic campaign(input int dly, input int n, input int abort_at,
                            input int rst_at, input bit hold_go);
        int d, p, np, stop_at, last;
        longint sum;
        logic [31:0] new_res, er, v;
        logic [3:0]  ev;
        d       = (dly == 0) ? 1 : dly;
        p       = d + SETTLE + GAP;
        np      = (1 << n) * p;
        sum     = 0;
        new_res = '0;
        stop_at = (abort_at != 0) ? abort_at : rst_at;
        last    = (stop_at != 0) ? stop_at + 2 : (hold_go ? np + 4 : np + 2);
        @(negedge clk);
        go           = 1'b1;
        delay_cycles = DLY_W'(dly);
        avg_log2     = 3'(n);
        tdc_count    = junk_val();
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (!hold_go) go = 1'b0;
            if (stop_at != 0 && c > stop_at)  ev = 4'b0000;
            else if (hold_go && c == np + 3)  ev = 4'b1010;
            else                              ev = exp_vec(c, d, np, p);
            check("ctl{start,stop,busy,done}", 64'({tdc_start, tdc_stop, busy, done}), 64'(ev));
            if (c == np + 1) new_res = 32'(sum >> n);
            if (rst_at != 0 && c > rst_at)          er = '0;
            else if (stop_at == 0 && c >= np + 1)   er = new_res;
            else                                    er = g_res;
            check("result", 64'(result), 64'(er));
            if (stop_at == 0 && c == np + 1) check_bytes("result_byte", new_res);
            if (rst_at != 0 && c == rst_at + 1) check_bytes("result_byte_rst", 32'h0);
            abort = (c == abort_at);
            rst_n = (c != rst_at);
            if (hold_go && c == np + 3) begin
                go    = 1'b0;
                abort = 1'b1;
            end
            if (c <= np && (c - 1) % p == d + SETTLE - 1) begin
                v         = sample_val();
                sum      += longint'(v);
                tdc_count = v;
            end else tdc_count = junk_val();
        end
        abort = 1'b0;
        go    = 1'b0;
        rst_n = 1'b1;
        if (rst_at != 0)        g_res = '0;
        else if (abort_at == 0) g_res = new_res;
    endtask

    initial begin
        int dly, n, d, np, ab;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({tdc_start, tdc_stop, busy, done}), 64'h0);
        check("rst_result", 64'(result), 64'h0);
        check_bytes("rst_byte", 32'h0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ctl", 64'({tdc_start, tdc_stop, busy, done}), 64'h0);
        end

        use_fixed = 1'b1;
        fixed_val = 32'h0000_1234;
        campaign(4, 0, 0, 0, 1'b0);
        check("single_result", 64'(result), 64'h1234);
        use_fixed = 1'b0;

        preset_q = '{32'd10, 32'd11, 32'd12, 32'd14};
        campaign(int'($urandom_range(1, 6)), 2, 0, 0, 1'b0);
        check("avg4_result", 64'(result), 64'd11);

        campaign(0, int'($urandom_range(0, 2)), 0, 0, 1'b0);

        // Abort in the first GAP cycle of the second of four measurements.
        campaign(3, 2, (3 + SETTLE + GAP) + 3 + SETTLE + 1, 0, 1'b0);

        campaign(2, 1, 0, 0, 1'b1);

        use_fixed = 1'b1;
        fixed_val = 32'hFFFF_FFFF;
        campaign(1, 7, 0, 0, 1'b0);
        check("sat_result", 64'(result), 64'hFFFF_FFFF);
        use_fixed = 1'b0;

        // Reset in the first SETTLE cycle.
        campaign(3, 1, 0, 3 + 1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            dly = int'($urandom_range(0, 12));
            n   = int'($urandom_range(0, 3));
            d   = (dly == 0) ? 1 : dly;
            np  = (1 << n) * (d + SETTLE + GAP);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, np)) : 0;
            campaign(dly, n, ab, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
